// File: rtl/i2s_pkg.sv
// Shared I2S definitions used by the 24-bit transmit and capture blocks.
//   I2S_DATA_W : sample width in bits
//   I2S_SLOT_W : SCK periods per half-frame (one channel slot)
//   sample_t   : signed PCM sample
//   ch_e       : word-select channel encoding (ws=0 left, ws=1 right)
package i2s_pkg;

  localparam int I2S_DATA_W = 24;
  localparam int I2S_SLOT_W = 32;

  typedef logic signed [I2S_DATA_W-1:0] sample_t;

  typedef enum logic {
    CH_LEFT  = 1'b0,
    CH_RIGHT = 1'b1
  } ch_e;

endpackage

// File: rtl/i2s_tx_shifter.sv
// I2S slot serialiser: slot bit counter, shift register and sd_o driver.
// Ports:
//   clk_i, rst_ni : system clock, async active-low reset
//   sck_fall      : one-cycle strobe, SCK falling edge seen this cycle
//   slot_start    : qualifies sck_fall as the first fall of a new slot
//   load_word     : sample to serialise, captured at slot_start
//   sd_o          : serial data, MSB first after one dummy bit
module i2s_tx_shifter
  import i2s_pkg::*;
#(
  parameter int DATA_W = I2S_DATA_W,
  parameter int SLOT_W = I2S_SLOT_W
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              sck_fall,
  input  logic              slot_start,
  input  logic [DATA_W-1:0] load_word,
  output logic              sd_o
);

  localparam int CNT_W = $clog2(SLOT_W);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(SLOT_W - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W);

  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] shift;

  // cnt=1 marks the fall after the dummy bit; counts 1..DATA_W emit data,
  // anything above pads with zeros and parks at CNT_MAX until the next slot.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt   <= CNT_MAX;
      shift <= '0;
      sd_o  <= 1'b0;
    end else if (sck_fall) begin
      if (slot_start) begin
        cnt   <= CNT_W'(1);
        shift <= load_word;
        sd_o  <= 1'b0;
      end else if (cnt != '0 && cnt <= CNT_LAST) begin
        sd_o  <= shift[DATA_W-1];
        shift <= {shift[DATA_W-2:0], 1'b0};
        cnt   <= cnt + 1'b1;
      end else begin
        sd_o <= 1'b0;
        if (cnt != CNT_MAX) begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/i2s_transmit_24.sv
// I2S 24-bit transmitter with valid/ready input and a one-pair holding buffer.
// SCK/WS are generated elsewhere synchronous to clk_i; this block only
// edge-detects them. Standard I2S one-bit delay, 24 data bits per 32-SCK slot.
// Ports:
//   clk_i, rst_ni        : system clock, async active-low reset
//   sck_i, ws_i          : I2S bit clock and word select (0=left, 1=right)
//   left_i, right_i      : signed PCM pair, taken when valid_i & ready_o
//   valid_i, ready_o     : input handshake (ready_o = holding buffer empty)
//   sd_o                 : serial data, changes after SCK falling edges
//   underrun_o           : one-cycle pulse when a left slot starts with no new pair
// Build option:
//   I2S_TX_MUTE_ON_UNDERRUN_EN : defined -> an underrun frame is sent as silence;
//                                undefined -> the previous frame is repeated.
module i2s_transmit_24
  import i2s_pkg::*;
#(
  parameter int DATA_W = I2S_DATA_W,
  parameter int SLOT_W = I2S_SLOT_W
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     sck_i,
  input  logic                     ws_i,
  input  logic signed [DATA_W-1:0] left_i,
  input  logic signed [DATA_W-1:0] right_i,
  input  logic                     valid_i,
  output logic                     ready_o,
  output logic                     sd_o,
  output logic                     underrun_o
);

  logic                     sck_d;
  logic                     ws_last;
  logic                     armed;
  logic                     hold_full;
  logic signed [DATA_W-1:0] hold_l, hold_r;
  logic signed [DATA_W-1:0] act_l, act_r;

  logic              sck_fall;
  logic              slot_start;
  logic              left_start;
  logic              accept;
  logic              transfer;
  logic              underrun;
  logic [DATA_W-1:0] load_word;

  assign sck_fall   = sck_d & ~sck_i;
  // Only a genuine WS change after arming starts a slot, so release from
  // reset in the middle of a slot never emits a partial word.
  assign slot_start = sck_fall & armed & (ws_i != ws_last);
  assign left_start = slot_start & (ch_e'(ws_i) == CH_LEFT);
  assign accept     = valid_i & ready_o;
  assign transfer   = left_start & hold_full;
  assign underrun   = left_start & ~hold_full;

  // The left word is taken straight from the holding buffer so the freshly
  // transferred sample goes out in the same slot that moves it into act_*.
  always_comb begin
    load_word = act_r;
    if (ch_e'(ws_i) == CH_LEFT) begin
      if (hold_full) begin
        load_word = hold_l;
      end else begin
`ifdef I2S_TX_MUTE_ON_UNDERRUN_EN
        load_word = '0;
`else
        load_word = act_l;
`endif
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sck_d      <= 1'b0;
      ws_last    <= 1'b0;
      armed      <= 1'b0;
      hold_full  <= 1'b0;
      hold_l     <= '0;
      hold_r     <= '0;
      act_l      <= '0;
      act_r      <= '0;
      ready_o    <= 1'b1;
      underrun_o <= 1'b0;
    end else begin
      sck_d      <= sck_i;
      underrun_o <= underrun;

      if (sck_fall) begin
        armed   <= 1'b1;
        ws_last <= ws_i;
      end

      if (transfer) begin
        act_l <= hold_l;
        act_r <= hold_r;
      end
`ifdef I2S_TX_MUTE_ON_UNDERRUN_EN
      else if (underrun) begin
        act_l <= '0;
        act_r <= '0;
      end
`endif

      // ready_o cannot be high while hold_full is set, so accept and
      // transfer never coincide.
      if (accept) begin
        hold_l    <= left_i;
        hold_r    <= right_i;
        hold_full <= 1'b1;
      end else if (transfer) begin
        hold_full <= 1'b0;
      end

      // Drops in the accept cycle; rises one cycle after the buffer empties.
      ready_o <= ~(hold_full | accept);
    end
  end

  i2s_tx_shifter #(
    .DATA_W (DATA_W),
    .SLOT_W (SLOT_W)
  ) u_shifter (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .sck_fall   (sck_fall),
    .slot_start (slot_start),
    .load_word  (load_word),
    .sd_o       (sd_o)
  );

endmodule
